// File: rtl/ch_sample_sequencer.sv
// rtl/ch_sample_sequencer.sv - per-channel buffer-group sampling sequencer
// Steps through groups of 2^mode buffers per accepted trigger, with holdoff and sticky overflow.

module ch_sample_sequencer #(
    parameter int NUM_BUF = 4,
    parameter int MODE_W  = $clog2($clog2(NUM_BUF) + 1),
    parameter int CNT_W   = $clog2(NUM_BUF + 1),
    parameter int HOLD_W  = 4
) (
    input  logic               clk,
    input  logic               RSTB,
    input  logic               trigger,
    input  logic               INST_START,
    input  logic               INST_STOP,
    input  logic               INST_READOUT,
    input  logic [MODE_W-1:0]  mode,
    input  logic [HOLD_W-1:0]  holdoff,
    output logic [2:0]         state,
    output logic [NUM_BUF-1:0] buf_active,
    output logic [CNT_W-1:0]   trigger_cnt,
    output logic               STOP_REQUEST,
    output logic               overflow
);

    localparam int               MAX_MODE = $clog2(NUM_BUF);
    localparam logic [NUM_BUF:0] ONE_W    = (NUM_BUF + 1)'(1);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_SAMPLING = 3'd1,
        ST_FULL     = 3'd2,
        ST_STOPPED  = 3'd3,
        ST_READOUT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BUF-1:0]  buf_active_q, buf_active_d;
    logic [CNT_W-1:0]    trigger_cnt_q, trigger_cnt_d;
    logic                stop_request_q, stop_request_d;
    logic                overflow_q, overflow_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [MODE_W-1:0]   mode_q, mode_d;

    logic trig_hist_q, start_hist_q, stop_hist_q, rd_hist_q;
    logic hist_valid_q;

    logic trig_rise, start_rise, stop_rise, rd_rise;
    logic [MODE_W-1:0]  mode_eff;
    logic [NUM_BUF:0]   start_mask_w;
    logic [NUM_BUF-1:0] shifted_mask;

    // History is not trusted until one clock after reset release, so a level
    // already high at release is never mistaken for an edge.
    assign trig_rise  = trigger      & ~trig_hist_q  & hist_valid_q;
    assign start_rise = INST_START   & ~start_hist_q & hist_valid_q;
    assign stop_rise  = INST_STOP    & ~stop_hist_q  & hist_valid_q;
    assign rd_rise    = INST_READOUT & ~rd_hist_q    & hist_valid_q;

    always_comb begin
        mode_eff       = (mode > MODE_W'(MAX_MODE)) ? MODE_W'(MAX_MODE) : mode;
        start_mask_w   = (ONE_W << (32'd1 << mode_eff)) - ONE_W;
        shifted_mask   = buf_active_q << (32'd1 << mode_q);

        state_d        = state_q;
        buf_active_d   = buf_active_q;
        trigger_cnt_d  = trigger_cnt_q;
        stop_request_d = stop_request_q;
        overflow_d     = overflow_q;
        mode_d         = mode_q;
        hold_cnt_d     = (hold_cnt_q != '0) ? hold_cnt_q - HOLD_W'(1) : '0;

        if (!(state_q inside {ST_INIT, ST_SAMPLING, ST_FULL, ST_STOPPED, ST_READOUT})) begin
            state_d = ST_INIT;
        end

        if (rd_rise) begin
            state_d      = ST_READOUT;
            buf_active_d = '0;
        end else if (stop_rise) begin
            // READOUT is only left through INST_START or reset.
            if (state_q != ST_READOUT) begin
                state_d      = ST_STOPPED;
                buf_active_d = '0;
            end
        end else if (start_rise) begin
            mode_d         = mode_eff;
            buf_active_d   = start_mask_w[NUM_BUF-1:0];
            trigger_cnt_d  = '0;
            stop_request_d = 1'b0;
            overflow_d     = 1'b0;
            hold_cnt_d     = '0;
            state_d        = ST_SAMPLING;
        end else if (trig_rise) begin
            if (state_q == ST_SAMPLING && hold_cnt_q == '0) begin
                trigger_cnt_d  = trigger_cnt_q + CNT_W'(1);
                stop_request_d = 1'b1;
                hold_cnt_d     = holdoff;
                buf_active_d   = shifted_mask;
                if (shifted_mask == '0) begin
                    state_d = ST_FULL;
                end
            end else if (state_q == ST_FULL) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            state_q        <= ST_INIT;
            buf_active_q   <= '0;
            trigger_cnt_q  <= '0;
            stop_request_q <= 1'b0;
            overflow_q     <= 1'b0;
            hold_cnt_q     <= '0;
            mode_q         <= '0;
            trig_hist_q    <= 1'b0;
            start_hist_q   <= 1'b0;
            stop_hist_q    <= 1'b0;
            rd_hist_q      <= 1'b0;
            hist_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_active_q   <= buf_active_d;
            trigger_cnt_q  <= trigger_cnt_d;
            stop_request_q <= stop_request_d;
            overflow_q     <= overflow_d;
            hold_cnt_q     <= hold_cnt_d;
            mode_q         <= mode_d;
            trig_hist_q    <= trigger;
            start_hist_q   <= INST_START;
            stop_hist_q    <= INST_STOP;
            rd_hist_q      <= INST_READOUT;
            hist_valid_q   <= 1'b1;
        end
    end

    assign state        = state_q;
    assign buf_active   = buf_active_q;
    assign trigger_cnt  = trigger_cnt_q;
    assign STOP_REQUEST = stop_request_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ch_sample_sequencer.sv
// tb/tb_ch_sample_sequencer.sv - self-checking bench for ch_sample_sequencer

module tb_ch_sample_sequencer;

    logic       clk;
    logic       RSTB;
    logic       trigger;
    logic       INST_START;
    logic       INST_STOP;
    logic       INST_READOUT;
    logic [1:0] mode;
    logic [3:0] holdoff;
    logic [2:0] state;
    logic [3:0] buf_active;
    logic [2:0] trigger_cnt;
    logic       STOP_REQUEST;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: group index and absolute cycle numbers instead of masks/counters.
    int m_state, m_g, m_grp, m_cnt, m_sr, m_ovf, m_next_ok, cyc;
    bit p_t, p_s, p_p, p_r;

    typedef struct {
        int t, s, p, r, md, st, ba, cnt, sr, ov;
    } vec_t;
    vec_t vecs[24];

    ch_sample_sequencer #(.NUM_BUF(4), .MODE_W(2), .CNT_W(3), .HOLD_W(4)) dut (
        .clk(clk), .RSTB(RSTB), .trigger(trigger), .INST_START(INST_START),
        .INST_STOP(INST_STOP), .INST_READOUT(INST_READOUT), .mode(mode),
        .holdoff(holdoff), .state(state), .buf_active(buf_active),
        .trigger_cnt(trigger_cnt), .STOP_REQUEST(STOP_REQUEST), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_ba();
        if (m_state == 1) return (((1 << m_g) - 1) << (m_grp * m_g)) & 15;
        return 0;
    endfunction

    task automatic model_edge(input bit t, s, p, r, input int md, input int hd);
        bit rt, rs, rp, rr;
        rt = t & ~p_t; rs = s & ~p_s; rp = p & ~p_p; rr = r & ~p_r;
        if (rr) begin
            m_state = 4;
        end else if (rp) begin
            if (m_state != 4) m_state = 3;
        end else if (rs) begin
            m_g = (md >= 2) ? 4 : (1 << md);
            m_grp = 0; m_cnt = 0; m_sr = 0; m_ovf = 0; m_next_ok = 0;
            m_state = 1;
        end else if (rt) begin
            if (m_state == 1 && cyc >= m_next_ok) begin
                m_cnt++;
                m_sr = 1;
                m_next_ok = cyc + hd + 1;
                m_grp++;
                if (m_grp * m_g >= 4) m_state = 2;
            end else if (m_state == 2) begin
                m_ovf = 1;
            end
        end
        p_t = t; p_s = s; p_p = p; p_r = r;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"}, int'(state), m_state);
        chk({tag, "_buf"}, int'(buf_active), exp_ba());
        chk({tag, "_cnt"}, int'(trigger_cnt), m_cnt);
        chk({tag, "_sreq"}, int'(STOP_REQUEST), m_sr);
        chk({tag, "_ovf"}, int'(overflow), m_ovf);
    endtask

    task automatic step(input bit t, s, p, r, input int md, input int hd);
        @(negedge clk);
        trigger = t; INST_START = s; INST_STOP = p; INST_READOUT = r;
        mode = 2'(md); holdoff = 4'(hd);
        @(posedge clk);
        #1;
        cyc++;
        model_edge(t, s, p, r, md, hd);
        check_model("mdl");
    endtask

    task automatic do_reset(input bit t, s, p, r);
        @(negedge clk);
        trigger = t; INST_START = s; INST_STOP = p; INST_READOUT = r;
        mode = 2'd3; holdoff = 4'd15;
        RSTB = 1'b0;
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_buf", int'(buf_active), 0);
        chk("rst_cnt", int'(trigger_cnt), 0);
        chk("rst_sreq", int'(STOP_REQUEST), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        RSTB = 1'b1;
        @(posedge clk);
        #1;
        m_state = 0; m_g = 1; m_grp = 0; m_cnt = 0; m_sr = 0; m_ovf = 0;
        m_next_ok = 0; cyc = 0;
        p_t = t; p_s = s; p_p = p; p_r = r;
        check_model("rel");
    endtask

    initial begin
        RSTB = 1'b0;
        trigger = 1'b0; INST_START = 1'b0; INST_STOP = 1'b0; INST_READOUT = 1'b0;
        mode = 2'd0; holdoff = 4'd0;

        vecs = '{
            '{0,1,0,0,1, 1, 3,0,0,0}, '{0,0,0,0,1, 1, 3,0,0,0},
            '{1,0,0,0,1, 1,12,1,1,0}, '{0,0,0,0,1, 1,12,1,1,0},
            '{1,0,0,0,1, 2, 0,2,1,0}, '{0,0,0,0,1, 2, 0,2,1,0},
            '{1,0,0,0,1, 2, 0,2,1,1}, '{0,0,0,0,1, 2, 0,2,1,1},
            '{0,0,1,0,1, 3, 0,2,1,1}, '{0,0,0,0,1, 3, 0,2,1,1},
            '{0,0,0,1,1, 4, 0,2,1,1}, '{0,0,1,0,1, 4, 0,2,1,1},
            '{0,0,0,0,1, 4, 0,2,1,1}, '{1,0,0,0,1, 4, 0,2,1,1},
            '{0,1,0,0,3, 1,15,0,0,0}, '{0,0,0,0,3, 1,15,0,0,0},
            '{1,0,0,0,3, 2, 0,1,1,0}, '{0,0,0,0,3, 2, 0,1,1,0},
            '{1,1,0,0,0, 1, 1,0,0,0}, '{0,0,0,0,0, 1, 1,0,0,0},
            '{1,0,0,0,0, 1, 2,1,1,0}, '{0,0,0,0,0, 1, 2,1,1,0},
            '{1,0,1,0,0, 3, 0,1,1,0}, '{0,0,0,0,0, 3, 0,1,1,0}
        };

        // Reset with all inputs high: release must not register any edge.
        do_reset(1, 1, 1, 1);
        repeat (3) step(1, 1, 1, 1, 3, 15);
        chk("rel_high_state", int'(state), 0);
        step(0, 0, 0, 0, 0, 0);

        // G=1: four triggers spaced 20 cycles walk a single bit to FULL.
        step(0, 1, 0, 0, 0, 0);
        chk("g1_start_buf", int'(buf_active), 1);
        for (int k = 1; k <= 4; k++) begin
            repeat (19) step(0, 0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0);
            chk("g1_buf", int'(buf_active), (k < 4) ? (1 << k) : 0);
            chk("g1_cnt", int'(trigger_cnt), k);
            chk("g1_state", int'(state), (k < 4) ? 1 : 2);
            chk("g1_sreq", int'(STOP_REQUEST), 1);
        end
        step(0, 0, 0, 0, 0, 0);

        // Holdoff 5: rise at t+3 ignored, rise at t+7 accepted.
        step(0, 1, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 5);
        chk("ho_first", int'(trigger_cnt), 1);
        step(0, 0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 5);
        chk("ho_blocked", int'(trigger_cnt), 1);
        repeat (3) step(0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 5);
        chk("ho_second", int'(trigger_cnt), 2);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].t[0], vecs[i].s[0], vecs[i].p[0], vecs[i].r[0], vecs[i].md, 0);
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            chk($sformatf("vec%0d_buf", i), int'(buf_active), vecs[i].ba);
            chk($sformatf("vec%0d_cnt", i), int'(trigger_cnt), vecs[i].cnt);
            chk($sformatf("vec%0d_sreq", i), int'(STOP_REQUEST), vecs[i].sr);
            chk($sformatf("vec%0d_ovf", i), int'(overflow), vecs[i].ov);
        end

        begin
            int hd;
            hd = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(999) == 0) begin
                    do_reset(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                end else begin
                    if ($urandom_range(49) == 0) hd = $urandom_range(0, 6);
                    step(1'($urandom_range(1)),
                         $urandom_range(99) < 4,
                         $urandom_range(99) < 2,
                         $urandom_range(99) < 1,
                         $urandom_range(0, 3), hd);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
